// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between fetch, the fetch queue and decode.
//   Enqueue side : in_valid / in_instr / in_pc / in_pcplus4 -> queue, in_ready <- queue
//   Dequeue side : out_valid / out_instr / out_pc / out_pcplus4 <- queue, out_ready -> queue
//   count        : queue occupancy, 0..DEPTH
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_pcplus4;
  logic                  in_ready;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_pcplus4;
  logic                  out_ready;

  logic [CW-1:0]         count;

  modport master (
    output in_valid, in_instr, in_pc, in_pcplus4, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pcplus4, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_pcplus4, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pcplus4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular instruction queue between fetch and decode.
// Each entry holds {instr, pc, pcplus4}. Head is presented first-word
// fall-through; an empty queue shows NOP / 0 on the outputs.
//   clk_i   : clock, all state on rising edge
//   rst_i   : synchronous active-high reset
//   flush_i : redirect, discards every entry (and any push/pop that cycle)
//   bus     : fetch_queue_if.slave (enqueue/dequeue handshakes + count)

// One storage slot. No reset: contents are only observed once written.
module fq_entry #(
  parameter int W = 96
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcplus4;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic [DEPTH-1:0][EW-1:0] ent;
  logic [DEPTH-1:0]         we;
  entry_t                   wr_ent;
  entry_t                   head;

  logic in_ready, out_valid, push, pop;

  // Handshake qualifiers depend only on registered occupancy, so in_ready
  // has no combinational path from out_ready (full blocks push even on pop).
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  assign wr_ent = '{instr: bus.in_instr, pc: bus.in_pc, pcplus4: bus.in_pcplus4};

  // Entry pushed during a flush/reset cycle is dropped, so no write either.
  always_comb begin
    we = '0;
    if (push && !flush_i && !rst_i) we[wr_ptr_q] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    fq_entry #(.W(EW)) u_ent (
      .clk_i (clk_i),
      .we_i  (we[i]),
      .d_i   (wr_ent),
      .q_o   (ent[i])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head = entry_t'(ent[rd_ptr_q]);

  // Empty queue shows a harmless NOP to decode rather than stale data.
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_instr   = out_valid ? head.instr   : NOP;
  assign bus.out_pc      = out_valid ? head.pc      : '0;
  assign bus.out_pcplus4 = out_valid ? head.pcplus4 : '0;
  assign bus.count       = count_q;
endmodule
